frost32_mem_arbiter: RTL and testbench

//  Shares the single Frost32 memory port between instruction fetch (IF) and data access (D) requesters.
//  - Arbitrates between the two requesters.
//  - Registers and sequences each transaction over the mem_req_access / mem_wait handshake.
//  - Rejects illegal sizes and misaligned accesses locally; aborts hung accesses on timeout.
//  - Sits between the CPU pipeline and the external bus (PortOut/PortIn_Frost32Cpu mem fields).

---
 rtl/frost32_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_frost32_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frost32_mem_arbiter.sv
// Frost32 memory port arbiter: shares one memory port between instruction fetch and data access.
// Optional macro FROST32_MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed D-over-IF priority.
module frost32_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic                  if_err,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_access_type,
    input  logic [1:0]            d_access_size,
    output logic                  d_done,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req_access,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_access_type,
    output logic [1:0]            mem_access_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wait,
    output logic                  busy,
    output logic                  owner
);

    // state   | meaning
    // S_IDLE  | no transaction; arbitrate and latch the winner's request
    // S_ISSUE | one-cycle mem_req_access strobe
    // S_WAIT  | waiting for mem_wait=0 or timeout
    // S_RESP  | one-cycle done pulse to the owner
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] SZ32  = 2'd0;
    localparam logic [1:0] SZ16  = 2'd1;
    localparam logic [1:0] SZBAD = 2'd3;

    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    type_q, type_d;
    logic [1:0]              size_q, size_d;
    logic                    owner_q, owner_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic grant_d;
    logic reject;

    always_comb begin
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
        // contested grant goes to whoever did not win last time
        grant_d = d_req && (!if_req || !owner_q);
`else
        grant_d = d_req;
`endif
        if (grant_d) begin
            reject = (d_access_size == SZBAD)
                  || ((d_access_size == SZ32) && (d_addr[1:0] != 2'b00))
                  || ((d_access_size == SZ16) && d_addr[0]);
        end else begin
            reject = (if_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        size_d  = size_q;
        owner_d = owner_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    owner_d = grant_d;
                    if (grant_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        type_d  = d_access_type;
                        size_d  = d_access_size;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        type_d  = 1'b0;
                        size_d  = SZ32;
                    end
                    if (reject) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_wait) begin
                    err_d   = 1'b0;
                    rdata_d = type_q ? '0 : mem_rdata;
                    state_d = S_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= 1'b0;
            size_q  <= SZ32;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            size_q  <= size_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign owner           = owner_q;
    assign mem_req_access  = (state_q == S_ISSUE);
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_access_type = type_q;
    assign mem_access_size = size_q;

    assign if_done  = (state_q == S_RESP) && !owner_q;
    assign d_done   = (state_q == S_RESP) &&  owner_q;
    assign if_err   = if_done && err_q;
    assign d_err    = d_done  && err_q;
    assign if_rdata = if_done ? rdata_q : '0;
    assign d_rdata  = d_done  ? rdata_q : '0;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Directed self-checking bench for frost32_mem_arbiter (built with TIMEOUT_CYCLES=8).
module tb_frost32_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req, if_done, if_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_access_type, d_done, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [1:0]    d_access_size;
    logic          mem_req_access, mem_access_type, mem_wait;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    mem_access_size;
    logic          busy, owner;

    int checks = 0;
    int errors = 0;

    frost32_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_access_type(d_access_type),
        .d_access_size(d_access_size), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req_access(mem_req_access), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // requester must hold req while it owns an unfinished transaction
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(busy && !owner && !if_done && !if_req)) else begin
                errors++;
                $error("FAIL protocol_if_req_dropped observed=0 expected=1");
            end
            assert (!(busy && owner && !d_done && !d_req)) else begin
                errors++;
                $error("FAIL protocol_d_req_dropped observed=0 expected=1");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int          n_exp, d_drop, i_drop, n, d_cnt, i_cnt;
    int          exp_who [4];
    int          exp_cyc [4];
    int          got_who [4];
    int          got_cyc [4];
    logic [31:0] t4_addr [5];
    logic [1:0]  t4_size [5];
    logic        t4_rej  [5];

    initial begin
        if_req = 0; if_addr = '0; d_req = 0; d_addr = '0; d_wdata = '0;
        d_access_type = 0; d_access_size = 2'd0; mem_rdata = '0; mem_wait = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check1 ("rst_busy", busy, 1'b0);
        check1 ("rst_req_access", mem_req_access, 1'b0);
        check1 ("rst_owner", owner, 1'b0);
        check1 ("rst_if_done", if_done, 1'b0);
        check1 ("rst_d_done", d_done, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_size", 32'(mem_access_size), 32'h0);
        rst_n = 1;
        tick;
        check1 ("rst_rel_busy", busy, 1'b0);

        // 1: IF only, zero wait
        if_addr = 32'h100; mem_rdata = 32'hDEADBEEF; mem_wait = 0; if_req = 1;
        check1 ("t1_c0_busy", busy, 1'b0);
        tick;
        check1 ("t1_c1_req_access", mem_req_access, 1'b1);
        check32("t1_c1_mem_addr", mem_addr, 32'h100);
        check1 ("t1_c1_type", mem_access_type, 1'b0);
        check1 ("t1_c1_owner", owner, 1'b0);
        tick;
        check1 ("t1_c2_req_access", mem_req_access, 1'b0);
        check1 ("t1_c2_if_done", if_done, 1'b0);
        tick;
        check1 ("t1_c3_if_done", if_done, 1'b1);
        check1 ("t1_c3_if_err", if_err, 1'b0);
        check32("t1_c3_if_rdata", if_rdata, 32'hDEADBEEF);
        check1 ("t1_c3_d_done", d_done, 1'b0);
        if_req = 0;
        tick;
        check1 ("t1_c4_if_done", if_done, 1'b0);
        check1 ("t1_c4_busy", busy, 1'b0);

        // 2: D write with four wait cycles
        d_addr = 32'h2000; d_wdata = 32'h12345678; d_access_type = 1; d_access_size = 2'd0;
        mem_wait = 1; d_req = 1;
        tick;
        check1 ("t2_c1_req_access", mem_req_access, 1'b1);
        check1 ("t2_c1_fields", (mem_addr == 32'h2000) && (mem_wdata == 32'h12345678)
                                && mem_access_type && (mem_access_size == 2'd0), 1'b1);
        for (int c = 2; c <= 6; c++) begin
            tick;
            check1 ("t2_wait_req_access", mem_req_access, 1'b0);
            check1 ("t2_wait_stable", (mem_addr == 32'h2000) && (mem_wdata == 32'h12345678)
                                      && mem_access_type && (mem_access_size == 2'd0), 1'b1);
            check1 ("t2_wait_d_done", d_done, 1'b0);
            check1 ("t2_wait_if_done", if_done, 1'b0);
            if (c == 6) mem_wait = 0;
        end
        tick;
        check1 ("t2_c7_d_done", d_done, 1'b1);
        check1 ("t2_c7_d_err", d_err, 1'b0);
        check32("t2_c7_d_rdata", d_rdata, 32'h0);
        check1 ("t2_c7_owner", owner, 1'b1);
        check1 ("t2_c7_if_done", if_done, 1'b0);
        d_req = 0;
        tick;
        check1 ("t2_c8_busy", busy, 1'b0);

        // 3: contention, requests held after done
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
        n_exp = 4; d_drop = 2; i_drop = 2;
        exp_who[0] = 1; exp_who[1] = 0; exp_who[2] = 1; exp_who[3] = 0;
        exp_cyc[0] = 3; exp_cyc[1] = 7; exp_cyc[2] = 11; exp_cyc[3] = 15;
`else
        n_exp = 3; d_drop = 2; i_drop = 1;
        exp_who[0] = 1; exp_who[1] = 1; exp_who[2] = 0; exp_who[3] = 0;
        exp_cyc[0] = 3; exp_cyc[1] = 7; exp_cyc[2] = 11; exp_cyc[3] = 0;
`endif
        mem_rdata = 32'h55AA0F0F; mem_wait = 0;
        if_addr = 32'h200; d_addr = 32'h300; d_access_type = 0; d_access_size = 2'd0;
        if_req = 1; d_req = 1;
        n = 0; d_cnt = 0; i_cnt = 0;
        for (int k = 0; k < 4; k++) begin got_who[k] = -1; got_cyc[k] = -1; end
        for (int c = 1; c <= 40 && n < n_exp; c++) begin
            tick;
            if (d_done) begin
                if (n < 4) begin got_who[n] = 1; got_cyc[n] = c; end
                n++; d_cnt++;
                check32("t3_d_rdata", d_rdata, 32'h55AA0F0F);
                if (d_cnt == d_drop) d_req = 0;
            end
            if (if_done) begin
                if (n < 4) begin got_who[n] = 0; got_cyc[n] = c; end
                n++; i_cnt++;
                check32("t3_if_rdata", if_rdata, 32'h55AA0F0F);
                if (i_cnt == i_drop) if_req = 0;
            end
        end
        if_req = 0; d_req = 0;
        check32("t3_done_count", 32'(n), 32'(n_exp));
        for (int k = 0; k < n_exp; k++) begin
            check32("t3_grant_who", 32'(got_who[k]), 32'(exp_who[k]));
            check32("t3_grant_cycle", 32'(got_cyc[k]), 32'(exp_cyc[k]));
        end
        tick;
        check1 ("t3_idle", busy, 1'b0);

        // 4: local rejects and aligned boundary cases
        t4_addr[0] = 32'h1001; t4_size[0] = 2'd1; t4_rej[0] = 1;
        t4_addr[1] = 32'h1002; t4_size[1] = 2'd0; t4_rej[1] = 1;
        t4_addr[2] = 32'h1000; t4_size[2] = 2'd3; t4_rej[2] = 1;
        t4_addr[3] = 32'h1002; t4_size[3] = 2'd1; t4_rej[3] = 0;
        t4_addr[4] = 32'h1003; t4_size[4] = 2'd2; t4_rej[4] = 0;
        mem_rdata = 32'hA5A5A5A5; mem_wait = 0;
        for (int v = 0; v < 5; v++) begin
            d_addr = t4_addr[v]; d_access_size = t4_size[v]; d_access_type = 0; d_req = 1;
            tick;
            if (t4_rej[v]) begin
                check1 ("t4_rej_d_done", d_done, 1'b1);
                check1 ("t4_rej_d_err", d_err, 1'b1);
                check1 ("t4_rej_no_access", mem_req_access, 1'b0);
                check32("t4_rej_rdata", d_rdata, 32'h0);
                d_req = 0;
                tick;
                check1 ("t4_rej_idle", busy, 1'b0);
                check1 ("t4_rej_no_access2", mem_req_access, 1'b0);
            end else begin
                check1 ("t4_ok_access", mem_req_access, 1'b1);
                check32("t4_ok_size", 32'(mem_access_size), 32'(t4_size[v]));
                tick;
                tick;
                check1 ("t4_ok_d_done", d_done, 1'b1);
                check1 ("t4_ok_d_err", d_err, 1'b0);
                check32("t4_ok_rdata", d_rdata, 32'hA5A5A5A5);
                d_req = 0;
                tick;
            end
        end
        if_addr = 32'h102; if_req = 1;
        tick;
        check1 ("t4_if_rej_done", if_done, 1'b1);
        check1 ("t4_if_rej_err", if_err, 1'b1);
        check1 ("t4_if_rej_no_access", mem_req_access, 1'b0);
        check32("t4_if_rej_rdata", if_rdata, 32'h0);
        if_req = 0;
        tick;

        // 5: timeout with mem_wait stuck high
        d_addr = 32'h40; d_access_size = 2'd0; d_access_type = 0; mem_rdata = 32'h77777777;
        mem_wait = 1; d_req = 1;
        tick;
        check1 ("t5_c1_access", mem_req_access, 1'b1);
        for (int c = 2; c <= 9; c++) begin
            tick;
            check1 ("t5_wait_no_done", d_done, 1'b0);
            check1 ("t5_wait_busy", busy, 1'b1);
        end
        tick;
        check1 ("t5_c10_d_done", d_done, 1'b1);
        check1 ("t5_c10_d_err", d_err, 1'b1);
        check32("t5_c10_rdata", d_rdata, 32'h0);
        d_req = 0;
        tick;
        check1 ("t5_c11_busy", busy, 1'b0);
        mem_wait = 0;

        // 6: async reset in WAIT, then a clean fetch
        d_addr = 32'h84; d_access_type = 0; d_access_size = 2'd0; mem_wait = 1; d_req = 1;
        tick;
        tick;
        check1 ("t6_wait_busy", busy, 1'b1);
        check1 ("t6_wait_owner", owner, 1'b1);
        #2 rst_n = 0;
        #1;
        check1 ("t6_rst_busy", busy, 1'b0);
        check1 ("t6_rst_owner", owner, 1'b0);
        check32("t6_rst_mem_addr", mem_addr, 32'h0);
        check1 ("t6_rst_access", mem_req_access, 1'b0);
        check1 ("t6_rst_d_done", d_done, 1'b0);
        d_req = 0; mem_wait = 0;
        tick;
        check1 ("t6_rst_no_done", d_done, 1'b0);
        rst_n = 1;
        if_addr = 32'h100; mem_rdata = 32'hCAFEF00D; if_req = 1;
        tick;
        check1 ("t6_c1_access", mem_req_access, 1'b1);
        tick;
        check1 ("t6_c2_no_done", if_done, 1'b0);
        tick;
        check1 ("t6_c3_if_done", if_done, 1'b1);
        check1 ("t6_c3_if_err", if_err, 1'b0);
        check32("t6_c3_if_rdata", if_rdata, 32'hCAFEF00D);
        check1 ("t6_c3_d_done", d_done, 1'b0);
        if_req = 0;
        tick;
        check1 ("t6_c4_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
